// File: rtl/sisc_ctrl_mc.sv
// sisc_ctrl_mc: multicycle control FSM for the SISC computer.
// Sequences fetch/decode/execute/mem/writeback with branch resolution, memory handshake and halt/fault.
module sisc_ctrl_mc #(
  parameter int STAT_W  = 4,
  parameter int AM_IMM  = 8,
  parameter int MEM_HS  = 1,
  parameter int MEM_TMO = 15
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic [3:0]        opcode,
  input  logic [STAT_W-1:0] mm,
  input  logic [STAT_W-1:0] stat,
  input  logic              mem_ack,
  output logic              rf_we,
  output logic              rf_wsel,
  output logic              wb_sel,
  output logic              imm_sel,
  output logic [1:0]        alu_op,
  output logic              stat_we,
  output logic              br_sel,
  output logic              pc_sel,
  output logic              pc_write,
  output logic              pc_rst,
  output logic              ir_load,
  output logic              mem_req,
  output logic              mem_we,
  output logic              halted,
  output logic              fault
);

  localparam logic [3:0] OP_LOD = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_SWP = 4'd3;
  localparam logic [3:0] OP_BRA = 4'd4;
  localparam logic [3:0] OP_BRR = 4'd5;
  localparam logic [3:0] OP_BNE = 4'd6;
  localparam logic [3:0] OP_BNR = 4'd7;
  localparam logic [3:0] OP_ALU = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam int CNT_W = $clog2(MEM_TMO + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(MEM_TMO - 1);

  typedef enum logic [3:0] {
    START0  = 4'd0,
    START1  = 4'd1,
    FETCH   = 4'd2,
    DECODE  = 4'd3,
    EXECUTE = 4'd4,
    MEM     = 4'd5,
    WB      = 4'd6,
    WB2     = 4'd7,
    HALT    = 4'd8,
    FAULT   = 4'd9
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;

  logic is_lod, is_str, is_swp, is_alu, is_mem, is_exec;
  logic is_pos_br, is_neg_br, is_rel, cc_hit, taken, mm_imm;

  assign is_lod    = (opcode == OP_LOD);
  assign is_str    = (opcode == OP_STR);
  assign is_swp    = (opcode == OP_SWP);
  assign is_alu    = (opcode == OP_ALU);
  assign is_mem    = is_lod | is_str;
  assign is_exec   = is_mem | is_swp | is_alu;
  assign is_pos_br = (opcode == OP_BRA) | (opcode == OP_BRR);
  assign is_neg_br = (opcode == OP_BNE) | (opcode == OP_BNR);
  assign is_rel    = (opcode == OP_BRR) | (opcode == OP_BNR);
  assign cc_hit    = |(stat & mm);
  assign taken     = (is_pos_br & cc_hit) | (is_neg_br & ~cc_hit);
  assign mm_imm    = (mm == STAT_W'(AM_IMM));

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= START1;
    else        state <= state_nxt;
  end

  // Counts MEM cycles spent without an acknowledge; zero on every MEM entry.
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)                         wait_cnt <= '0;
    else if (state == MEM && !mem_ack)  wait_cnt <= wait_cnt + CNT_W'(1);
    else                                wait_cnt <= '0;
  end

  always_comb begin
    state_nxt = state;
    rf_we     = 1'b0;
    rf_wsel   = 1'b0;
    wb_sel    = 1'b0;
    imm_sel   = 1'b0;
    alu_op    = 2'b10;
    stat_we   = 1'b0;
    br_sel    = 1'b0;
    pc_sel    = 1'b0;
    pc_write  = 1'b0;
    pc_rst    = 1'b0;
    ir_load   = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    halted    = 1'b0;
    fault     = 1'b0;
    case (state)
      START0: begin
        pc_rst    = 1'b1;
        state_nxt = START1;
      end
      START1: begin
        pc_rst    = 1'b1;
        state_nxt = FETCH;
      end
      FETCH: begin
        ir_load   = 1'b1;
        pc_write  = 1'b1;
        state_nxt = DECODE;
      end
      DECODE: begin
        br_sel = is_rel;
        if (taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
        end
        if (opcode == OP_HLT) state_nxt = HALT;
        else if (is_exec)     state_nxt = EXECUTE;
        else                  state_nxt = FETCH;
      end
      EXECUTE: begin
        if (is_alu) begin
          alu_op  = 2'b01;
          imm_sel = mm_imm;
        end else if (is_mem) begin
          alu_op  = 2'b00;
          imm_sel = 1'b1;
        end else begin
          alu_op  = 2'b00;
        end
        state_nxt = is_mem ? MEM : WB;
      end
      MEM: begin
        alu_op  = 2'b00;
        imm_sel = 1'b1;
        mem_req = 1'b1;
        mem_we  = is_str;
        // An ack arriving on the last permitted cycle still completes the access.
        if (MEM_HS == 0 || mem_ack) state_nxt = is_lod ? WB : FETCH;
        else if (wait_cnt == TMO_LAST) state_nxt = FAULT;
        else state_nxt = MEM;
      end
      WB: begin
        rf_we = 1'b1;
        if (is_alu) begin
          stat_we = 1'b1;
          alu_op  = 2'b01;
          imm_sel = mm_imm;
        end else if (is_lod) begin
          wb_sel = 1'b1;
        end
        state_nxt = is_swp ? WB2 : FETCH;
      end
      WB2: begin
        rf_we     = 1'b1;
        rf_wsel   = 1'b1;
        state_nxt = FETCH;
      end
      HALT:    halted = 1'b1;
      FAULT:   fault  = 1'b1;
      default: state_nxt = START0;
    endcase
  end

endmodule
